// File: rtl/cnn_pkg.sv
// Shared CNN definitions: activation type, layer dimensions, address widths
// and the pooling FSM state encoding.
package cnn_pkg;

  localparam int DATA_W    = 16;
  localparam int C1_DIM    = 24;
  localparam int P1_DIM    = 12;
  localparam int C1_ADDR_W = 10;
  localparam int P1_ADDR_W = 8;

  typedef logic signed [DATA_W-1:0] act_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_TOP,
    RD_BOT,
    DRAIN
  } pool_state_t;

endpackage

// File: rtl/pool_addr_gen.sv
// Window walker for 2x2/stride-2 pooling: walks windows (i,j) in raster
// order, issuing the top row pair then the bottom row pair of each window
// on the two read ports. Address, strobe and phase outputs are registered so
// they line up with the cycle the read is issued.
module pool_addr_gen
  import cnn_pkg::*;
#(
  parameter int IN_DIM    = cnn_pkg::C1_DIM,
  parameter int OUT_DIM   = cnn_pkg::P1_DIM,
  parameter int IN_ADDR_W = cnn_pkg::C1_ADDR_W,
  parameter int WIN_W     = cnn_pkg::P1_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 launch,
  output logic                 rd_en,
  output logic                 is_bot,
  output logic [IN_ADDR_W-1:0] rd_addr1,
  output logic [IN_ADDR_W-1:0] rd_addr2,
  output logic [WIN_W-1:0]     win_idx,
  output logic                 last_window
);

  localparam int CNT_W = $clog2(OUT_DIM);

  logic [CNT_W-1:0]     i_reg, i_next, j_reg, j_next;
  logic [WIN_W-1:0]     k_reg, k_next;
  logic                 bot_reg, bot_next, en_reg, en_next;
  logic                 last_cur;
  logic [IN_ADDR_W-1:0] row_ext, row_base, base_next, addr_next;

  assign last_cur    = (i_reg == CNT_W'(OUT_DIM - 1)) && (j_reg == CNT_W'(OUT_DIM - 1));
  assign last_window = en_reg && last_cur;
  assign rd_en       = en_reg;
  assign is_bot      = bot_reg;
  assign win_idx     = k_reg;

  // Next window/phase: top -> bottom of the same window, then step j (and i on wrap)
  always_comb begin
    i_next   = i_reg;
    j_next   = j_reg;
    k_next   = k_reg;
    bot_next = bot_reg;
    en_next  = en_reg;
    if (launch) begin
      i_next   = '0;
      j_next   = '0;
      k_next   = '0;
      bot_next = 1'b0;
      en_next  = 1'b1;
    end else if (en_reg) begin
      if (!bot_reg) begin
        bot_next = 1'b1;
      end else begin
        bot_next = 1'b0;
        if (last_cur) begin
          en_next = 1'b0;
        end else begin
          k_next = k_reg + 1'b1;
          if (j_reg == CNT_W'(OUT_DIM - 1)) begin
            j_next = '0;
            i_next = i_reg + 1'b1;
          end else begin
            j_next = j_reg + 1'b1;
          end
        end
      end
    end
  end

  // Input row of the next issue is 2i + phase
  assign row_ext = IN_ADDR_W'({i_next, bot_next});

  if (IN_DIM == 24) begin : g_shift_add
    assign row_base = (row_ext << 4) + (row_ext << 3);
  end else begin : g_generic_mul
    assign row_base = IN_ADDR_W'(row_ext * IN_DIM);
  end

  assign base_next = row_base + (IN_ADDR_W'(j_next) << 1);
  assign addr_next = en_next ? base_next : '0;

  // Register counters and the addresses of the issue happening next cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_reg    <= '0;
      j_reg    <= '0;
      k_reg    <= '0;
      bot_reg  <= 1'b0;
      en_reg   <= 1'b0;
      rd_addr1 <= '0;
      rd_addr2 <= '0;
    end else begin
      i_reg    <= i_next;
      j_reg    <= j_next;
      k_reg    <= k_next;
      bot_reg  <= bot_next;
      en_reg   <= en_next;
      rd_addr1 <= addr_next;
      rd_addr2 <= en_next ? addr_next + 1'b1 : '0;
    end
  end

endmodule

// File: rtl/pool1_maxpool_unit.sv
// Pool1: 2x2 stride-2 max pooling of the 24x24 Conv1 map into the 12x12
// Pool1 memory. One window per two cycles; the compare pipeline follows
// the read latency via a tag shift register of depth RD_LAT.
// Optional feature: define POOL1_RELU_EN to clamp negative pooled values to 0.
module pool1_maxpool_unit
  import cnn_pkg::*;
#(
  parameter int DATA_W     = cnn_pkg::DATA_W,
  parameter int IN_DIM     = cnn_pkg::C1_DIM,
  parameter int OUT_DIM    = cnn_pkg::P1_DIM,
  parameter int IN_ADDR_W  = cnn_pkg::C1_ADDR_W,
  parameter int OUT_ADDR_W = cnn_pkg::P1_ADDR_W,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [IN_ADDR_W-1:0]  rd_addr1,
  output logic [IN_ADDR_W-1:0]  rd_addr2,
  input  logic [DATA_W-1:0]     rd_data1,
  input  logic [DATA_W-1:0]     rd_data2,
  output logic                  wr_en,
  output logic [OUT_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data
);

  typedef logic signed [DATA_W-1:0] pix_t;
  localparam int TAG_W = OUT_ADDR_W + 3;

  pool_state_t state;
  logic        launch;
  logic        ag_bot, ag_last;
  logic [OUT_ADDR_W-1:0] ag_win;

  logic [RD_LAT-1:0][TAG_W-1:0] tag_pipe;
  logic [TAG_W-1:0]      tag_arr;
  logic                  arr_v, arr_b, arr_l;
  logic [OUT_ADDR_W-1:0] arr_w;
  pix_t d1, d2, pair_max, win_max, max_top;
  logic wr_last;

  // A new pass is only accepted from IDLE; start while busy is dropped
  assign launch = start && (state == IDLE);

  pool_addr_gen #(
    .IN_DIM   (IN_DIM),
    .OUT_DIM  (OUT_DIM),
    .IN_ADDR_W(IN_ADDR_W),
    .WIN_W    (OUT_ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .launch     (launch),
    .rd_en      (rd_en),
    .is_bot     (ag_bot),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .win_idx    (ag_win),
    .last_window(ag_last)
  );

  // Tag of the read whose data is on rd_data this cycle
  assign tag_arr = tag_pipe[RD_LAT-1];
  assign arr_v   = tag_arr[TAG_W-1];
  assign arr_b   = tag_arr[TAG_W-2];
  assign arr_l   = tag_arr[TAG_W-3];
  assign arr_w   = tag_arr[OUT_ADDR_W-1:0];

  // Signed max of the arriving pair, and of that with the held top-row max
  always_comb begin
    d1       = pix_t'(rd_data1);
    d2       = pix_t'(rd_data2);
    pair_max = (d1 > d2) ? d1 : d2;
    win_max  = (max_top > pair_max) ? max_top : pair_max;
  end

  // Delay issue tags by the memory read latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= {rd_en, ag_bot, ag_last, ag_win};
      for (int s = 1; s < RD_LAT; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  // Hold top-row max, then register the window result onto the write port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_top <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_last <= 1'b0;
    end else begin
      wr_en <= arr_v && arr_b;
      if (arr_v && !arr_b) begin
        max_top <= pair_max;
      end
      if (arr_v && arr_b) begin
        wr_addr <= arr_w;
        wr_last <= arr_l;
`ifdef POOL1_RELU_EN
        wr_data <= win_max[DATA_W-1] ? '0 : win_max;
`else
        wr_data <= win_max;
`endif
      end
    end
  end

  // Pass sequencing: mirrors the issue phase and waits for the final write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RD_TOP;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        RD_TOP: state <= RD_BOT;
        RD_BOT: state <= ag_last ? DRAIN : RD_TOP;
        DRAIN: begin
          if (wr_en && wr_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
